// File: rtl/inference_run_controller_if.sv
// Handshake between the run controller and the neural_network core.
// The controller drives start; the core returns done and its argmax digit.
interface inference_run_controller_if;
  logic       nn_start;
  logic       nn_done;
  logic [3:0] nn_argmax;

  modport master (
    output nn_start,
    input  nn_done,
    input  nn_argmax
  );

  modport slave (
    input  nn_start,
    output nn_done,
    output nn_argmax
  );
endinterface

// File: rtl/inference_run_controller.sv
// Sequences one neural_network run per start-switch edge and latches the result.
// Optional watchdog abort is built only when INFER_TIMEOUT_EN is defined.
module inference_run_controller #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000,
  parameter int unsigned CYC_W          = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_req,
  input  logic                        abort,
  input  logic                        clear,
  inference_run_controller_if.master  nn,
  output logic                        busy,
  output logic                        result_valid,
  output logic [3:0]                  result,
  output logic [CYC_W-1:0]            cycle_count,
  output logic                        timeout,
  output logic [1:0]                  state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [CYC_W-1:0] CntOne = {{(CYC_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             go;
  logic [CYC_W-1:0] run_cnt_q, run_cnt_d, cnt_inc;
  logic             valid_q, valid_d;
  logic [3:0]       result_q, result_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
  logic             timeout_q, timeout_d;
  logic             wd_hit;

  // start_req is asynchronous: two synchronizer flops plus one history flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= start_req;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign go      = s2_q & ~s3_q;
  assign cnt_inc = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CntOne;

`ifdef INFER_TIMEOUT_EN
  localparam logic [CYC_W-1:0] TimeoutLim = CYC_W'(TIMEOUT_CYCLES);
  assign wd_hit = (cnt_inc >= TimeoutLim);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_hit             = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    valid_d       = valid_q;
    result_d      = result_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;

    // Applied first so a same-cycle done latch or watchdog overrides it.
    if (clear) begin
      valid_d   = 1'b0;
      result_d  = 4'hF;
      timeout_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d   = StRun;
          run_cnt_d = '0;
        end
      end
      StRun: begin
        run_cnt_d = cnt_inc;
        if (nn.nn_done) begin
          state_d       = StFlush;
          result_d      = (nn.nn_argmax <= 4'd9) ? nn.nn_argmax : 4'hA;
          valid_d       = 1'b1;
          cycle_count_d = cnt_inc;
        end else if (abort) begin
          state_d = StFlush;
        end else if (wd_hit) begin
          state_d   = StFlush;
          timeout_d = 1'b1;
          result_d  = 4'hE;
          valid_d   = 1'b0;
        end
      end
      StFlush: begin
        if (!nn.nn_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      run_cnt_q     <= '0;
      valid_q       <= 1'b0;
      result_q      <= 4'hF;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      valid_q       <= valid_d;
      result_q      <= result_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  assign nn.nn_start  = (state_q == StRun);
  assign busy         = (state_q != StIdle);
  assign state        = state_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign cycle_count  = cycle_count_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/inference_run_controller.md
# inference_run_controller

Sequences one inference of the `neural_network` core per user request and latches its result for display. It sits between the board controls and `neural_network` in `neural_network_top`. It synchronizes and edge-detects the start switch, and holds the core's `start` level until `done` is seen. It latches the argmax digit and the run's cycle count, then waits for `done` to clear before re-arming. An optional watchdog aborts runs that never complete.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32'd2_000_000: RUN cycles before watchdog abort (used only with the macro).
- `CYC_W`, default 32: width of the cycle counter and the `cycle_count` output.

Ports:
- `clk`  in  1: single clock, `CLOCK_50` domain, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `start_req`  in  1: raw level from a switch; asynchronous to `clk`.
- `abort`  in  1: synchronous; ends the run without latching a result.
- `clear`  in  1: synchronous; clears `result_valid` and sets `result` to 4'hF.
- `nn_done`  in  1: `done` from `neural_network`.
- `nn_argmax`  in  4: `argmax_output` from `neural_network`.
- `nn_start`  out  1: `start` to `neural_network`.
- `busy`  out  1: high in RUN and FLUSH.
- `result_valid`  out  1: a latched result is available.
- `result`  out  4: latched digit; 4'hA means out-of-range; 4'hF means none.
- `cycle_count`  out  CYC_W: RUN-cycle count latched at the end of the last run.
- `timeout`  out  1: sticky watchdog flag; constant 0 without the macro.
- `state`  out  2: debug; IDLE=0, RUN=1, FLUSH=2.

## Operation
- Synchronizer: `start_req` passes through 2 flops (s1, s2), then a history flop s3. The request edge is `go = s2 & ~s3`.
- IDLE:
  - `nn_start`=0; `nn_done` is ignored.
  - `go` moves the FSM to RUN, clears the run counter, and keeps `result` and `result_valid` unchanged.
  - A `start_req` held high does not retrigger; a new rising edge is required.
- RUN:
  - `nn_start`=1.
  - The run counter increments each cycle and saturates at all-ones.
  - Exit priority, highest first:
    - `nn_done`=1: latch `result`, `result_valid`←1, `cycle_count`←counter+1, go to FLUSH.
    - `abort`=1: go to FLUSH; results are untouched.
    - Watchdog: go to FLUSH.
- Result latch rule: `result` = `nn_argmax` if it is ≤9; otherwise 4'hA.
- FLUSH:
  - `nn_start`=0.
  - Moves to IDLE on the first cycle `nn_done`=0. If `nn_done` is already low, FLUSH lasts exactly 1 cycle.
- `clear` in any state:
  - Sets `result_valid`←0 and `result`←4'hF; does not change the FSM state.
  - If `clear` and a done-latch occur in the same cycle, the latch wins.
- `nn_start`, `busy` and `state` decode directly from the state register, so they are glitch-free registered-state outputs.
- Reset values:
  - state = IDLE; s1, s2, s3 = 0.
  - `nn_start`=0, `busy`=0, `result_valid`=0, `result`=4'hF, `cycle_count`=0, `timeout`=0.
- Reset mid-run: `nn_start` drops asynchronously with `reset`, and no result is latched.

## Timing
- Request latency: `start_req` first sampled high at edge 0 → s2=1 after edge 1 → state=RUN and `nn_start`=1 after edge 2.
- Done latency: `nn_done` sampled high at edge n → `result`, `result_valid`, `cycle_count` update and `nn_start`=0 after edge n.
- Cycle count: `cycle_count` equals the number of edges with state=RUN, including the done edge.
- Minimum request pitch: RUN(≥1) + FLUSH(≥1) + IDLE(1) cycles. Requests arriving in RUN or FLUSH are dropped.

## Configuration
- Macro: `INFER_TIMEOUT_EN`.
- Defined:
  - When the RUN counter reaches `TIMEOUT_CYCLES` with `nn_done`=0, the FSM goes to FLUSH.
  - `timeout`←1 (sticky until `reset` or `clear`).
  - `result`←4'hE and `result_valid`←0.
- Undefined:
  - No comparator is built; RUN waits indefinitely; `timeout` is tied to 0.

## Test plan
- Normal run:
  - Stimulus: reset, then raise `start_req` at edge 0; model drives `nn_done`=1 with `nn_argmax`=7 at the 100th RUN edge, and drops it 3 cycles later.
  - Expected: `nn_start` high after edge 2; `result`=7, `result_valid`=1, `cycle_count`=100; `busy` stays high through FLUSH, then the FSM returns to IDLE.
- Held switch: keep `start_req` high after the run completes → no second `nn_start`. Lower and raise `start_req` → a second run starts 2 edges later.
- Out-of-range result: `nn_argmax`=4'd12 at done → `result`=4'hA, `result_valid`=1.
- Same-cycle clear and done: `clear` pulsed on the same edge as `nn_done` → `result_valid`=1 with the new result. `clear` pulsed one edge later → `result`=4'hF, `result_valid`=0.
- Abort and reset:
  - `abort` in RUN → FLUSH, with `result` and `cycle_count` unchanged.
  - `reset` asserted mid-RUN → `nn_start`=0 immediately, all outputs at their reset values.
- With `INFER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50: `nn_done` never asserts → after 50 RUN edges `timeout`=1, `result`=4'hE, `nn_start`=0, FSM in IDLE.
